keyboard_ahb_buf: RTL
=====================

# keyboard_ahb_buf

AHB-Lite slave that captures key events from the 4x4 matrix keypad scanner (`keyboard_top`) and exposes them to the METEO_SoC CPU. It detects each new key press on the scanner's `key_disp` output and queues the 4-bit key code in a small FIFO. The CPU drains the FIFO through memory-mapped registers, and a level interrupt signals pending keys. The block sits directly downstream of `keyboard_top` on the AHB peripheral bus.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `HCLK` in 1: system clock; `keyboard_top` runs on the same clock.
- `RSTn` in 1: asynchronous active-low reset.
- `key_disp` in 5: scanner output, synchronous to `HCLK`.
  - bit4 = a key is pressed.
  - bits3:0 = key code 0..15, valid only when bit4 = 1.
- `HSEL` in 1: slave select.
- `HADDR` in 32: address; only bits 3:2 are decoded.
- `HTRANS` in 2: transfer type; a transfer is active when bit1 = 1 (NONSEQ or SEQ).
- `HWRITE` in 1: write strobe.
- `HSIZE` in 3: ignored; all accesses are treated as word accesses.
- `HWDATA` in 32: write data.
- `HREADY` in 1: bus ready.
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: constant 1.
- `HRESP` out 1: constant 0.
- `key_irq` out 1: level interrupt.

## Operation
- Key event detection:
  - `key_disp` is registered once as `prev`.
  - A push is requested when `en` = 1, `key_disp[4]` = 1, and either `prev[4]` = 0 or `key_disp[3:0]` differs from `prev[3:0]`.
  - A held key produces exactly one event.
- Address decode uses HADDR[3:2]:
  - 0x0 DATA (RO): [3:0] = head code, [8] = 1 if the FIFO was non-empty. A read pops the FIFO when it is non-empty; a read of an empty FIFO returns 0 and has no side effect.
  - 0x4 STATUS (RO): [0] empty, [1] full, [2] overflow (sticky), [8:4] count.
  - 0x8 CTRL (RW): [0] `en`, [1] `irq_en`; all other bits read 0.
  - 0xC CMD (WO, reads 0): writing 1 to bit0 flushes the FIFO; writing 1 to bit2 clears overflow.
- Address-phase capture:
  - Sampled when `HSEL & HTRANS[1] & HREADY`: the access-valid flag, `HWRITE`, and HADDR[3:2].
  - Write data is taken from `HWDATA` in the following data phase.
- FIFO behaviour:
  - Push while full with no simultaneous pop: the event is dropped and overflow is set.
  - Simultaneous push and pop: both take effect, count is unchanged, and a push into a full FIFO is accepted.
  - Flush resets the pointers and count in the cycle the write completes; a push in that same cycle is discarded.
- Interrupt: `key_irq` = `irq_en & ~empty`, driven from a register.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.

## Timing
- Reset values:
  - FIFO empty; pointers and count 0.
  - overflow 0, `en` 0, `irq_en` 0.
  - `prev` = 0.
  - `HRDATA` = 0, `key_irq` = 0.
  - `HREADYOUT` = 1, `HRESP` = 0.
- Zero wait states.
- `HRDATA` is valid in the data phase, computed combinationally from the registered address and current state.
- A DATA pop updates the pointer at the clock edge that ends the data phase.
- Key-to-FIFO latency:
  - Entry is written at the first edge where the edge condition holds.
  - STATUS reflects the entry on the next read.
  - `key_irq` rises one cycle after the push edge.
- CTRL write takes effect at the data-phase end edge. Events arriving in that same cycle use the old `en`.
- Reset mid-transfer aborts the transfer, and all state returns to reset values immediately.

## Structure
- Package `keyboard_buf_pkg` holds:
  - register offset constants for DATA, STATUS, CTRL and CMD;
  - STATUS and CTRL bit positions;
  - `KEY_VALID_BIT` = 4.
- Sub-module `key_fifo` is a synchronous FIFO with ports `push`, `pop`, `flush`, `din[3:0]`, `dout`, `empty`, `full` and `count`, parameterised by `DEPTH`.
- The top level contains edge detection, AHB decode, the control and overflow registers, and `key_irq`.

## Test plan
- Reset:
  - Stimulus: CTRL=0x3; `key_disp` steps 0x00 → 0x15 (held 50 cycles) → 0x00.
  - Required: exactly one entry; STATUS=0x010; `key_irq`=1; DATA read=0x105; then STATUS=0x001 and `key_irq`=0.
- Code change while held:
  - Stimulus: `key_disp` 0x13 → 0x17 with no release.
  - Required: two entries, read back in order 0x103, 0x107.
- Overflow with DEPTH=8:
  - Stimulus: 9 distinct presses.
  - Required: STATUS=0x086; the first 8 codes are read back in order. After CMD write 0x4, STATUS bit2=0.
- Simultaneous push and pop when full:
  - Stimulus: DATA read whose data phase coincides with a new press.
  - Required: count stays 8; overflow stays 0; the new code is read last.
- Disabled:
  - Stimulus: `en`=0, 3 presses.
  - Required: STATUS=0x001; a DATA read returns 0x000.
- Flush:
  - Stimulus: 3 entries, then CMD write 0x1.
  - Required: STATUS=0x001; `key_irq` drops the next cycle.
- Async reset:
  - Stimulus: assert `RSTn` low mid-read with 5 entries queued.
  - Required: all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/keyboard_ahb_buf_pkg.sv
// Shared constants for the keypad event buffer: register map, STATUS/CTRL/CMD
// bit positions and the key-valid bit of the scanner output.
package keyboard_buf_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_CMD    = 2'd3
   } reg_sel_e;

   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CTRL   = 4'h8;
   localparam logic [3:0] OFF_CMD    = 4'hC;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_COUNT_LSB = 4;
   localparam int ST_COUNT_W   = 5;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;

   localparam int CMD_FLUSH   = 0;
   localparam int CMD_CLR_OVF = 2;

   localparam int DATA_VALID_BIT = 8;
   localparam int KEY_VALID_BIT  = 4;

   function automatic reg_sel_e addr_to_sel(input logic [1:0] a_word);
      reg_sel_e sel;
      case ({a_word, 2'b00})
         OFF_DATA:   sel = REG_DATA;
         OFF_STATUS: sel = REG_STATUS;
         OFF_CTRL:   sel = REG_CTRL;
         OFF_CMD:    sel = REG_CMD;
         default:    sel = REG_DATA;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/keyboard_ahb_buf_if.sv
// AHB-Lite peripheral-bus bundle between the CPU fabric and the keypad buffer.
interface keyboard_ahb_buf_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/keyboard_ahb_buf_key_fifo.sv
// Synchronous FIFO of 4-bit key codes; a push into a full FIFO is accepted
// only when a pop happens in the same cycle. Flush wins over push and pop.
module key_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [3:0]                 din,
   output logic [3:0]                 dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_do_pop;
   logic          w_do_push;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign count     = r_count;
   assign dout      = r_mem[r_rptr];
   assign w_do_pop  = pop & ~empty & ~flush;
   assign w_do_push = push & (~full | w_do_pop) & ~flush;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/keyboard_ahb_buf.sv
// AHB-Lite slave that queues new key presses from the matrix scanner and lets
// the CPU drain them through DATA/STATUS/CTRL/CMD registers with a level IRQ.
module keyboard_ahb_buf
   import keyboard_buf_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                      HCLK,
   input  logic                      RSTn,
   input  logic [4:0]                key_disp,
   keyboard_ahb_buf_if.slave         ahb,
   output logic                      key_irq
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [4:0]    r_prev;
   logic          r_dp_valid;
   logic          r_dp_write;
   reg_sel_e      r_dp_sel;
   logic          r_en;
   logic          r_irq_en;
   logic          r_ovf;
   logic          r_irq;

   logic          w_key_new;
   logic          w_rd;
   logic          w_wr;
   logic          w_pop;
   logic          w_flush;
   logic          w_clr_ovf;
   logic          w_ovf_set;
   logic [3:0]    w_dout;
   logic          w_empty;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic [31:0]   w_rdata;
   logic          w_unused;

   // A held key re-registers into r_prev every cycle, so only a fresh press or
   // a code change while held looks new.
   assign w_key_new = r_en & key_disp[KEY_VALID_BIT] &
                      (~r_prev[KEY_VALID_BIT] | (key_disp[3:0] != r_prev[3:0]));

   assign w_rd      = r_dp_valid & ~r_dp_write;
   assign w_wr      = r_dp_valid &  r_dp_write;
   assign w_pop     = w_rd & (r_dp_sel == REG_DATA) & ~w_empty;
   assign w_flush   = w_wr & (r_dp_sel == REG_CMD) & ahb.HWDATA[CMD_FLUSH];
   assign w_clr_ovf = w_wr & (r_dp_sel == REG_CMD) & ahb.HWDATA[CMD_CLR_OVF];
   assign w_ovf_set = w_key_new & w_full & ~w_pop & ~w_flush;

   key_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (HCLK),
      .rst_n (RSTn),
      .push  (w_key_new),
      .pop   (w_pop),
      .flush (w_flush),
      .din   (key_disp[3:0]),
      .dout  (w_dout),
      .empty (w_empty),
      .full  (w_full),
      .count (w_count)
   );

   always_ff @(posedge HCLK or negedge RSTn) begin
      if (!RSTn) begin
         r_prev     <= '0;
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
         r_dp_sel   <= REG_DATA;
      end else begin
         r_prev <= key_disp;
         if (ahb.HREADY) begin
            r_dp_valid <= ahb.HSEL & ahb.HTRANS[1];
            r_dp_write <= ahb.HWRITE;
            r_dp_sel   <= addr_to_sel(ahb.HADDR[3:2]);
         end
      end
   end

   always_ff @(posedge HCLK or negedge RSTn) begin
      if (!RSTn) begin
         r_en     <= 1'b0;
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && r_dp_sel == REG_CTRL) begin
            r_en     <= ahb.HWDATA[CTRL_EN];
            r_irq_en <= ahb.HWDATA[CTRL_IRQ_EN];
         end
         // A drop in the same cycle as a clear still leaves the flag set.
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_clr_ovf) r_ovf <= 1'b0;
         r_irq <= r_irq_en & ~w_empty;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_rd) begin
         case (r_dp_sel)
            REG_DATA: begin
               if (!w_empty) begin
                  w_rdata[3:0]           = w_dout;
                  w_rdata[DATA_VALID_BIT] = 1'b1;
               end
            end
            REG_STATUS: begin
               w_rdata[ST_EMPTY] = w_empty;
               w_rdata[ST_FULL]  = w_full;
               w_rdata[ST_OVF]   = r_ovf;
               w_rdata[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_count);
            end
            REG_CTRL: begin
               w_rdata[CTRL_EN]     = r_en;
               w_rdata[CTRL_IRQ_EN] = r_irq_en;
            end
            default: w_rdata = '0;
         endcase
      end
   end

   assign ahb.HRDATA    = w_rdata;
   assign ahb.HREADYOUT = 1'b1;
   assign ahb.HRESP     = 1'b0;
   assign key_irq       = r_irq;

   assign w_unused = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0],
                       ahb.HTRANS[0], ahb.HWDATA[31:3]};
endmodule
